thunderbird_gen2: RTL and testbench

THUNDERBIRD_GEN2 -- requirements
Module: thunderbird_gen2

---
 rtl/thunderbird_gen2.sv | 128 ++++++++++++
 tb/tb_thunderbird_gen2.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/thunderbird_gen2.sv
// Thunderbird-style sequential turn/hazard lamp controller, N_LAMP lamps per side.
// Optional brake override is compiled in with `define THUNDERBIRD_BRAKE_EN.
module thunderbird_gen2 #(
  parameter int N_LAMP = 3,
  parameter int TICK   = 25000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_left,
  input  logic                  i_right,
  input  logic                  i_haz,
  input  logic                  i_brake,
  output logic [2*N_LAMP-1:0]   o_led,
  output logic                  o_busy
);

  localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N_LAMP-1:0]     side_q, side_d;     // thermometer, bit 0 = innermost lamp
  logic                  blink_q, blink_d;
  logic [2*N_LAMP-1:0]   led_q, led_d;
  logic                  busy_q, busy_d;

  logic                  eff_haz;
  logic                  step;
  logic [N_LAMP-1:0]     side_rev;
  logic [N_LAMP-1:0]     fill;

  assign eff_haz = i_haz | (i_left & i_right);
  assign step    = (cnt_q == LAST);

  // Right-side lamps grow downward from bit N_LAMP-1, so mirror the thermometer.
  for (genvar gi = 0; gi < N_LAMP; gi++) begin : g_rev
    assign side_rev[gi] = side_d[N_LAMP-1-gi];
  end

`ifdef THUNDERBIRD_BRAKE_EN
  assign fill = {N_LAMP{i_brake}};
`else
  logic unused_brake;
  assign unused_brake = i_brake;
  assign fill         = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = step ? '0 : cnt_q + CW'(1);
    side_d  = side_q;
    blink_d = blink_q;

    if (eff_haz) begin
      if (state_q != HAZ) begin
        state_d = HAZ;
        cnt_d   = '0;
        side_d  = '0;
        blink_d = 1'b1;
      end else if (step) begin
        blink_d = ~blink_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          side_d = '0;
          if (i_left) begin
            state_d = LEFT;
            side_d  = N_LAMP'(1);
          end else if (i_right) begin
            state_d = RIGHT;
            side_d  = N_LAMP'(1);
          end
        end
        LEFT, RIGHT: begin
          if (step) begin
            if (&side_q) begin
              state_d = IDLE;
              side_d  = '0;
            end else begin
              side_d = {side_q[N_LAMP-2:0], 1'b1};
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          side_d  = '0;
          blink_d = 1'b0;
        end
      endcase
    end

    // Lamp image is built from the next state so every output is a plain flop.
    case (state_d)
      HAZ:     led_d = {(2*N_LAMP){blink_d}};
      LEFT:    led_d = {side_d, fill};
      RIGHT:   led_d = {fill, side_rev};
      default: led_d = {fill, fill};
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      side_q  <= '0;
      blink_q <= 1'b0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      side_q  <= side_d;
      blink_q <= blink_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_thunderbird_gen2.sv
// Directed scoreboard bench for thunderbird_gen2 with N_LAMP=3, TICK=4.
module tb_thunderbird_gen2;

  logic       clk;
  logic       rst_n;
  logic       left, right, haz, brake;
  logic [5:0] led;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] led;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

`ifdef THUNDERBIRD_BRAKE_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  thunderbird_gen2 #(.N_LAMP(3), .TICK(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_left  (left),
    .i_right (right),
    .i_haz   (haz),
    .i_brake (brake),
    .o_led   (led),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({led, busy} === {e.led, e.busy}) else begin
      failures++;
      $error("FAIL %s: led=%b busy=%b expected led=%b busy=%b",
             e.tag, led, busy, e.led, e.busy);
    end
  endtask

  // Expect the given outputs after each of the next n rising edges.
  task automatic cyc(input int n, input logic [5:0] exp_led, input logic exp_busy,
                     input string tag);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.led  = exp_led;
      e.busy = exp_busy;
      e.tag  = $sformatf("%s[%0d]", tag, k);
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_head();
    end
  endtask

  // Check outputs right now, with no clock edge in between.
  task automatic now_check(input logic [5:0] exp_led, input logic exp_busy,
                           input string tag);
    exp_t e;
    e.led  = exp_led;
    e.busy = exp_busy;
    e.tag  = tag;
    sb.push_back(e);
    compare_head();
  endtask

  initial begin
    rst_n = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    haz   = 1'b0;
    brake = 1'b0;
    #1;
    now_check(6'b000000, 1'b0, "reset_init");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(2, 6'b000000, 1'b0, "idle");

    // Single-cycle left pulse; a right request mid-sequence is ignored.
    left = 1'b1;
    cyc(1, 6'b001000, 1'b1, "left_s1");
    left = 1'b0;
    cyc(3, 6'b001000, 1'b1, "left_s1_hold");
    cyc(1, 6'b011000, 1'b1, "left_s2");
    right = 1'b1;
    cyc(3, 6'b011000, 1'b1, "left_s2_ignore_r");
    right = 1'b0;
    cyc(4, 6'b111000, 1'b1, "left_s3");
    cyc(2, 6'b000000, 1'b0, "left_done");

    // Right held: one off cycle between sequences.
    right = 1'b1;
    cyc(4, 6'b000100, 1'b1, "right_s1");
    cyc(4, 6'b000110, 1'b1, "right_s2");
    cyc(4, 6'b000111, 1'b1, "right_s3");
    cyc(1, 6'b000000, 1'b0, "right_gap");
    cyc(4, 6'b000100, 1'b1, "right_again_s1");
    cyc(1, 6'b000110, 1'b1, "right_again_s2");

    // Hazard interrupts the right sequence.
    haz = 1'b1;
    cyc(4, 6'b111111, 1'b1, "haz_on");
    cyc(4, 6'b000000, 1'b1, "haz_off_phase");
    cyc(1, 6'b111111, 1'b1, "haz_on2");
    haz   = 1'b0;
    right = 1'b0;
    cyc(2, 6'b000000, 1'b0, "haz_release");

    // Both turn requests act as hazard.
    left  = 1'b1;
    right = 1'b1;
    cyc(4, 6'b111111, 1'b1, "lr_haz_on");
    cyc(4, 6'b000000, 1'b1, "lr_haz_off");
    cyc(1, 6'b111111, 1'b1, "lr_haz_on2");
    left  = 1'b0;
    right = 1'b0;
    cyc(1, 6'b000000, 1'b0, "lr_release");

    // Brake in IDLE.
    brake = 1'b1;
    cyc(2, BRK ? 6'b111111 : 6'b000000, 1'b0, "brake_idle");
    brake = 1'b0;
    cyc(1, 6'b000000, 1'b0, "brake_idle_rel");

    // Brake during LEFT lights the right side only.
    left = 1'b1;
    cyc(1, 6'b001000, 1'b1, "bl_s1");
    left = 1'b0;
    cyc(3, 6'b001000, 1'b1, "bl_s1_hold");
    cyc(1, 6'b011000, 1'b1, "bl_s2");
    brake = 1'b1;
    cyc(1, BRK ? 6'b011111 : 6'b011000, 1'b1, "brake_left");
    brake = 1'b0;
    cyc(1, 6'b011000, 1'b1, "brake_left_rel");

    // Asynchronous reset mid-sequence, then a fresh sequence.
    #2 rst_n = 1'b0;
    #1;
    now_check(6'b000000, 1'b0, "reset_async");
    #2 rst_n = 1'b1;
    cyc(2, 6'b000000, 1'b0, "post_reset_idle");
    left = 1'b1;
    cyc(1, 6'b001000, 1'b1, "post_reset_s1");
    left = 1'b0;
    cyc(3, 6'b001000, 1'b1, "post_reset_s1_hold");
    cyc(1, 6'b011000, 1'b1, "post_reset_s2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
